module_bcd_param: RTL and testbench
===================================

Name: module_bcd_param

Overview:
- Parametrised, handshaked binary-to-BCD converter for the display path; next generation of the fixed 16-bit, four-digit converter.
- Converts a WIDTH-bit binary value into DIGITS packed BCD digits using sequential double-dabble: one shift/add-3 iteration per clock.
- Adds over-range detection, a start/busy/done handshake and an optional signed mode.
- Sits between the arithmetic core and the 7-segment multiplexer.

Parameters:
- WIDTH, 16: binary input width; legal range 4..32.
- DIGITS, 5: number of BCD output digits; legal range 1..10.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled on a rising edge of clk.
- numero_input  in  WIDTH  binary operand; captured on the accepting edge only.
- bcd_output  out  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k].
- overflow  out  1  result exceeded 10^DIGITS-1; valid while listo is high and held afterwards.
- busy  out  1  conversion in progress.
- listo  out  1  one-cycle completion pulse.
- sign_output  out  1  only present with BCD_SIGNED_EN; 1 = negative result.

Behaviour:
- Single clock domain (clk); reset synchronous, active-high (rst).
- Reset:
  - On reset: bcd_output=0, overflow=0, busy=0, listo=0, sign_output=0, FSM in IDLE, iteration counter=0.
  - Reset asserted mid-conversion aborts the conversion; no listo is produced for it.
- FSM states:
  - IDLE: wait for start.
  - CONVERT: perform iterations.
  - DONE: update outputs.
- Accept:
  - Condition: edge E0 with state IDLE and start=1.
  - Latch numero_input into a shift register, clear the BCD scratch register, counter=WIDTH, busy=1 from the cycle after E0.
  - Over-range flag computed from the latched operand: operand > 10^DIGITS-1, evaluated at least 4*DIGITS+4 bits wide.
- CONVERT:
  - Each edge: every scratch digit >= 5 gets +3, then the {scratch, operand} concatenation shifts left 1; counter decrements.
  - After WIDTH iterations (edge E0+WIDTH), go to DONE.
- DONE (edge E0+WIDTH+1):
  - bcd_output <= scratch; or all digits 9 (saturated) when over-range.
  - overflow <= over-range flag.
  - listo=1 for exactly that one cycle; busy=0 in the same cycle; state returns to IDLE.
- Latency: listo high in the cycle after edge E0+WIDTH+1, i.e. WIDTH+2 clock cycles after the accepting edge. Default: 18 cycles.
- start while busy=1 is ignored; no queueing; numero_input changes while busy have no effect.
- start high in the listo cycle is accepted (state is IDLE); back-to-back throughput is one conversion per WIDTH+2 cycles.
- start held high continuously: a new conversion is accepted every WIDTH+2 cycles.
- Outputs bcd_output, overflow and sign_output hold their last values until the next DONE or reset.
- Input 0 yields all-zero digits with overflow=0.
- Boundary values:
  - 10^DIGITS-1 converts exactly, overflow=0.
  - 10^DIGITS saturates to all 9s, overflow=1.

Optional Feature:
- Macro: BCD_SIGNED_EN.
- Defined:
  - numero_input is two's complement; sign_output port exists.
  - At accept, the magnitude (negate if MSB=1) is latched into the WIDTH-bit operand, unsigned. The most negative value converts correctly, e.g. -32768 -> 32768.
  - sign_output is updated at DONE with the input MSB, and is 0 for zero.
  - Over-range is tested on the magnitude.
- Undefined: input is unsigned; sign_output port is absent; no negate logic.

Test Plan:
- Default params, rst for 2 cycles, then start with 1234 -> listo pulse exactly 18 cycles after accept; bcd_output=0x01234, overflow=0, busy low in the listo cycle.
- WIDTH=16, DIGITS=5, 65535 then 0 -> 0x65535, then 0x00000, overflow=0 both times.
- DIGITS=4, inputs 9999 and 12345 -> 0x9999 overflow=0; 0x9999 overflow=1.
- Accept 5678; pulse start with 910 at cycle 5 of busy; then start with 910 in the listo cycle -> first result 0x05678, 910 ignored, second result 0x00910 exactly 18 cycles later.
- Accept 4321; assert rst at cycle 8 for 1 cycle -> all outputs 0, no listo; a new start with 7 -> 0x00007 after 18 cycles.
- With BCD_SIGNED_EN, inputs -910 (0xFC72) and -32768 -> sign_output=1 with 0x00910; sign_output=1 with 0x32768.

Source files
------------

// File: rtl/module_bcd_param_if.sv
// Handshake/result bundle for module_bcd_param.
//   start        : conversion request (master -> converter)
//   numero_input : WIDTH-bit binary operand (master -> converter)
//   bcd_output   : 4*DIGITS packed BCD result, units in [3:0]
//   overflow     : operand exceeded 10^DIGITS-1 (held until next result)
//   busy         : conversion in progress
//   listo        : one-cycle completion pulse
//   sign_output  : result sign, only with BCD_SIGNED_EN defined
interface module_bcd_param_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      numero_input;
  logic [4*DIGITS-1:0]   bcd_output;
  logic                  overflow;
  logic                  busy;
  logic                  listo;
`ifdef BCD_SIGNED_EN
  logic                  sign_output;
`endif

  modport master (
    output start, numero_input,
    input  bcd_output, overflow, busy, listo
`ifdef BCD_SIGNED_EN
    , input sign_output
`endif
  );

  modport slave (
    input  start, numero_input,
    output bcd_output, overflow, busy, listo
`ifdef BCD_SIGNED_EN
    , output sign_output
`endif
  );
endinterface

// File: rtl/module_bcd_param.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/listo
// handshake and over-range saturation. One shift/add-3 iteration per clock;
// listo pulses WIDTH+2 cycles after the accepting edge.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : module_bcd_param_if.slave (start, numero_input, bcd_output,
//          overflow, busy, listo, and sign_output when BCD_SIGNED_EN)
// Optional macro BCD_SIGNED_EN: treat numero_input as two's complement,
// convert the magnitude and report the sign on sign_output.
module module_bcd_param #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  module_bcd_param_if.slave   bus
);

  localparam int unsigned BW    = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned CMP_W = (WIDTH > BW + 4) ? WIDTH : BW + 4;

  function automatic logic [CMP_W-1:0] max_value();
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < DIGITS; i++) p = p * 10;
    return CMP_W'(p - 1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_VAL = max_value();
  localparam logic [BW-1:0]    SAT_VAL = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    operand;
  logic [WIDTH-1:0]    operand_in;
  logic [BW-1:0]       scratch;
  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [CNT_W-1:0]    count;
  logic                over_range;
  logic                over_range_in;
  logic [BW-1:0]       bcd_q;
  logic                ovf_q;
  logic                listo_q;
  logic                accept;
  logic                iterate;
  logic                finish;
  logic                busy_c;

`ifdef BCD_SIGNED_EN
  logic sign_in;
  logic sign_pend;
  logic sign_q;

  // Negating the most negative value wraps to itself, which read as
  // unsigned is exactly its magnitude.
  assign sign_in    = bus.numero_input[WIDTH-1];
  assign operand_in = sign_in ? (~bus.numero_input + WIDTH'(1))
                              : bus.numero_input;
`else
  assign operand_in = bus.numero_input;
`endif

  assign over_range_in = CMP_W'(operand_in) > MAX_VAL;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (bus.start) state_nxt = S_CONVERT;
      S_CONVERT: if (count == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs / datapath strobes
  always_comb begin
    accept  = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    busy_c  = 1'b0;
    unique case (state)
      S_IDLE:    accept  = bus.start;
      S_CONVERT: begin iterate = 1'b1; busy_c = 1'b1; end
      S_DONE:    begin finish  = 1'b1; busy_c = 1'b1; end
      default:   ;
    endcase
  end

  // Add-3 correction on every digit, then shift {scratch, operand} left.
  always_comb begin
    adj = scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    shifted = {adj, operand} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      operand    <= '0;
      scratch    <= '0;
      count      <= '0;
      over_range <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      listo_q    <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_pend  <= 1'b0;
      sign_q     <= 1'b0;
`endif
    end else begin
      listo_q <= 1'b0;
      if (accept) begin
        operand    <= operand_in;
        scratch    <= '0;
        count      <= CNT_W'(WIDTH);
        over_range <= over_range_in;
`ifdef BCD_SIGNED_EN
        sign_pend  <= sign_in;
`endif
      end
      if (iterate) begin
        {scratch, operand} <= shifted;
        count              <= count - CNT_W'(1);
      end
      if (finish) begin
        bcd_q   <= over_range ? SAT_VAL : scratch;
        ovf_q   <= over_range;
        listo_q <= 1'b1;
`ifdef BCD_SIGNED_EN
        sign_q  <= sign_pend;
`endif
      end
    end
  end

  assign bus.bcd_output = bcd_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = busy_c;
  assign bus.listo      = listo_q;
`ifdef BCD_SIGNED_EN
  assign bus.sign_output = sign_q;
`endif

endmodule

// File: tb/tb_module_bcd_param.sv
// Directed bench for module_bcd_param: a 5-digit and a 4-digit instance,
// hand-computed BCD results, latency, handshake and reset-abort checks.
module tb_module_bcd_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  module_bcd_param_if #(.WIDTH(16), .DIGITS(5)) bus5 ();
  module_bcd_param_if #(.WIDTH(16), .DIGITS(4)) bus4 ();

  module_bcd_param #(.WIDTH(16), .DIGITS(5)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  module_bcd_param #(.WIDTH(16), .DIGITS(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_listo(input bit sel4);
    return sel4 ? bus4.listo : bus5.listo;
  endfunction

  // Present an operand with start for one edge (the accepting edge).
  task automatic start_conv(input bit sel4, input logic [15:0] v);
    if (sel4) begin bus4.start = 1'b1; bus4.numero_input = v; end
    else      begin bus5.start = 1'b1; bus5.numero_input = v; end
    tick();
    bus4.start = 1'b0;
    bus5.start = 1'b0;
  endtask

  // Count edges (accepting edge = 1) until listo is seen; bounded.
  task automatic wait_done(input bit sel4, input int n0, output int n);
    n = n0;
    while (!get_listo(sel4) && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic conv_check(input bit sel4, input logic [15:0] v,
                            input logic [63:0] exp_bcd, input bit exp_ovf,
                            input string tag);
    int n;
    start_conv(sel4, v);
    check({tag, "_busy"}, sel4 ? bus4.busy : bus5.busy, 1);
    wait_done(sel4, 1, n);
    check({tag, "_lat"}, n, 18);
    check({tag, "_bcd"}, sel4 ? bus4.bcd_output : bus5.bcd_output, exp_bcd);
    check({tag, "_ovf"}, sel4 ? bus4.overflow : bus5.overflow, exp_ovf);
    check({tag, "_busy_at_listo"}, sel4 ? bus4.busy : bus5.busy, 0);
    tick();
    check({tag, "_listo_pulse"}, get_listo(sel4), 0);
  endtask

  initial begin
    int n;
    int seen;
    bus5.start = 1'b0; bus5.numero_input = '0;
    bus4.start = 1'b0; bus4.numero_input = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_bcd",   bus5.bcd_output, 0);
    check("rst_ovf",   bus5.overflow, 0);
    check("rst_busy",  bus5.busy, 0);
    check("rst_listo", bus5.listo, 0);

    conv_check(0, 16'd1234, 64'h01234, 0, "c1234");
    tick(); tick();
    check("hold_bcd", bus5.bcd_output, 64'h01234);

`ifdef BCD_SIGNED_EN
    conv_check(0, 16'hFFFF, 64'h00001, 0, "cffff");
    check("cffff_sign", bus5.sign_output, 1);
`else
    conv_check(0, 16'hFFFF, 64'h65535, 0, "c65535");
`endif
    conv_check(0, 16'd0, 64'h00000, 0, "c0");

    conv_check(1, 16'd9999,  64'h9999, 0, "d4_9999");
    conv_check(1, 16'd10000, 64'h9999, 1, "d4_10000");
    conv_check(1, 16'd12345, 64'h9999, 1, "d4_12345");
    conv_check(1, 16'd42,    64'h0042, 0, "d4_42");

    // start while busy is ignored; start in the listo cycle is accepted
    start_conv(0, 16'd5678);
    n = 1;
    repeat (5) begin tick(); n++; end
    bus5.start = 1'b1; bus5.numero_input = 16'd910;
    tick(); n++;
    bus5.start = 1'b0;
    wait_done(0, n, n);
    check("ign_lat", n, 18);
    check("ign_bcd", bus5.bcd_output, 64'h05678);
    bus5.start = 1'b1; bus5.numero_input = 16'd910;
    tick();
    bus5.start = 1'b0;
    wait_done(0, 1, n);
    check("b2b_lat", n, 18);
    check("b2b_bcd", bus5.bcd_output, 64'h00910);
    tick();

    // reset mid-conversion aborts with no listo
    start_conv(0, 16'd4321);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_bcd",  bus5.bcd_output, 0);
    check("abort_ovf",  bus5.overflow, 0);
    check("abort_busy", bus5.busy, 0);
    seen = 0;
    repeat (25) begin
      if (bus5.listo) seen++;
      tick();
    end
    check("abort_no_listo", seen, 0);
    conv_check(0, 16'd7, 64'h00007, 0, "c7");

`ifdef BCD_SIGNED_EN
    check("c7_sign", bus5.sign_output, 0);
    conv_check(0, 16'hFC72, 64'h00910, 0, "cm910");
    check("cm910_sign", bus5.sign_output, 1);
    conv_check(0, 16'h8000, 64'h32768, 0, "cm32768");
    check("cm32768_sign", bus5.sign_output, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
